jtag_debug_host_shifter: RTL and testbench

- Host-side sequencer for the Nios II debug slave virtual-JTAG interface. It drives the same signals the debug slave consumes: ir_in, tck, tdi, the virtual state strobes and rti. It also samples tdo.
- Accepts one command (IR value + shift data) over a valid/ready handshake. It runs the IR-update, capture, shift, update and run-test-idle sequence on a divided tck, then returns the captured shift data.
- Used for on-chip self-test and simulation of the debug path without an external JTAG cable.

---
 rtl/jtag_debug_host_shifter.sv | 167 ++++++++++++++++
 tb/tb_jtag_debug_host_shifter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_host_shifter.sv
// jtag_debug_host_shifter
// Host-side sequencer for the debug slave virtual-JTAG port. It accepts one
// command (IR + shift data) and walks UIR, CDR, SDR (SR_WIDTH bits), UDR and
// RTI on a divided tck. It then presents the bits captured from tdo.
// Optional build macro: DBG_HOST_IR_CACHE_EN. It skips UIR when the IR is
// unchanged since the last command.
module jtag_debug_host_shifter #(
  parameter int unsigned SR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti,
  output logic                busy
);

  localparam int unsigned BW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
  localparam int unsigned PW = $clog2(2 * TCK_DIV);

  localparam logic [PW-1:0] P_RISE = PW'(TCK_DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(2 * TCK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(SR_WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UIR  = 3'd1;
  localparam logic [2:0] S_CDR  = 3'd2;
  localparam logic [2:0] S_SDR  = 3'd3;
  localparam logic [2:0] S_UDR  = 3'd4;
  localparam logic [2:0] S_RTI  = 3'd5;
  localparam logic [2:0] S_RSP  = 3'd6;

  logic [2:0]          state;
  logic [PW-1:0]       pcnt;
  logic [BW-1:0]       bit_cnt;
  logic [SR_WIDTH-1:0] sh_q;
  logic                accept;
  logic                active;
  logic                period_end;
  logic                rise_edge;
  logic                uir_skip;

  // Handshake and tck-phase decode
  always_comb begin
    accept     = cmd_valid && cmd_ready;
    active     = (state != S_IDLE) && (state != S_RSP);
    period_end = active && (pcnt == P_LAST);
    rise_edge  = active && (pcnt == P_RISE);
  end

`ifdef DBG_HOST_IR_CACHE_EN
  logic ir_cache_vld;

  // ir_in already holds the cached IR; this flag says it came from a real UIR
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ir_cache_vld <= 1'b0;
    else if (accept) ir_cache_vld <= 1'b1;
  end

  // Skip UIR when the requested IR is already loaded in the slave
  always_comb uir_skip = ir_cache_vld && (cmd_ir == ir_in);
`else
  // UIR runs on every transaction
  always_comb uir_skip = 1'b0;
`endif

  // Sequencer: every JTAG state advances only at the end of a tck period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept)     state <= uir_skip ? S_CDR : S_UIR;
        S_UIR:  if (period_end) state <= S_CDR;
        S_CDR:  if (period_end) state <= S_SDR;
        S_SDR:  if (period_end && (bit_cnt == B_LAST)) state <= S_UDR;
        S_UDR:  if (period_end) state <= S_RTI;
        S_RTI:  if (period_end) state <= S_RSP;
        S_RSP:  if (rsp_valid && rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // tck divider: low phase first, held low outside the JTAG states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      tck  <= 1'b0;
    end else if (!active) begin
      pcnt <= '0;
      tck  <= 1'b0;
    end else begin
      pcnt <= period_end ? '0 : pcnt + 1'b1;
      if (rise_edge)       tck <= 1'b1;
      else if (period_end) tck <= 1'b0;
    end
  end

  // Shift datapath: tdi is launched at a period start, tdo is captured on the tck rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q     <= '0;
      bit_cnt  <= '0;
      tdi      <= 1'b0;
      rsp_data <= '0;
      ir_in    <= '0;
    end else begin
      if ((state == S_IDLE) && accept) begin
        sh_q  <= cmd_data;
        ir_in <= cmd_ir;
      end
      if ((state == S_SDR) && rise_edge) rsp_data[bit_cnt] <= tdo;
      if (period_end) begin
        if (state == S_CDR) begin
          tdi  <= sh_q[0];
          sh_q <= sh_q >> 1;
        end else if (state == S_SDR) begin
          if (bit_cnt == B_LAST) begin
            bit_cnt <= '0;
            tdi     <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tdi     <= sh_q[0];
            sh_q    <= sh_q >> 1;
          end
        end
      end
    end
  end

  // Response/command handshake. rsp_valid rises one clk after RSP is entered,
  // which gives the (SR_WIDTH+4)*2*TCK_DIV + 1 accept-to-response latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      if ((state == S_RSP) && !rsp_valid) rsp_valid <= 1'b1;
      else if (rsp_valid && rsp_ready)    rsp_valid <= 1'b0;
      cmd_ready <= ((state == S_IDLE) && !accept) || (rsp_valid && rsp_ready);
    end
  end

  assign vs_uir         = (state == S_UIR);
  assign vs_cdr         = (state == S_CDR);
  assign vs_sdr         = (state == S_SDR);
  assign vs_udr         = (state == S_UDR);
  assign jtag_state_rti = (state == S_RTI);
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_jtag_debug_host_shifter.sv
// tb_jtag_debug_host_shifter
// Directed and randomized commands against a transaction-level reference.
// The reference supplies the expected response (loopback data or the tdo
// pattern), the accept-to-response latency, the strobe widths/order and the
// IR-cache skip decision (when DBG_HOST_IR_CACHE_EN is defined).
module tb_jtag_debug_host_shifter;

  localparam int unsigned SR  = 38;
  localparam int unsigned IRW = 2;
  localparam int unsigned DIV = 2;
  localparam int unsigned PER = 2 * DIV;
  localparam int unsigned LAT = (SR + 4) * PER + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir;
  logic [SR-1:0]  cmd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [SR-1:0]  rsp_data;
  logic           tck, tdi, tdo;
  logic [IRW-1:0] ir_in;
  logic           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, busy;

  jtag_debug_host_shifter #(.SR_WIDTH(SR), .IR_WIDTH(IRW), .TCK_DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(jtag_state_rti), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference-side state
  logic          loop_mode;
  logic [SR-1:0] pat;
  logic [SR-1:0] exp_data;
  logic [IRW-1:0] exp_ir;
  logic          mon_en;
  int            sdr_idx;
  int            tdi_bad;
  int            n_str [5];
  int            seq;
  int            overlap;
  int            ir_bad;
  logic [4:0]    prev_str;
  bit            m_cache_vld;
  logic [IRW-1:0] m_cache_ir;

  logic [49:0] outs_all;
  assign outs_all = {cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in,
                     vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, busy};

  // Slave stand-in: echo tdi, or play back one pattern bit per shift period
  always_comb begin
    if (loop_mode)       tdo = tdi;
    else if (sdr_idx < SR) tdo = pat[sdr_idx];
    else                 tdo = 1'b0;
  end

  // One tck rise per shifted bit: check the launched tdi bit, advance the bit index
  always @(posedge tck) begin
    if (mon_en && vs_sdr) begin
      if (sdr_idx < SR) begin
        if (tdi !== exp_data[sdr_idx]) tdi_bad++;
      end
      sdr_idx++;
    end
  end

  // Strobe widths, exclusivity, order of appearance and ir_in while strobing
  always @(negedge clk) begin
    logic [4:0] str;
    if (mon_en) begin
      str = {jtag_state_rti, vs_udr, vs_sdr, vs_cdr, vs_uir};
      for (int i = 0; i < 5; i++) begin
        if (str[i]) n_str[i]++;
        if (str[i] && !prev_str[i]) seq = seq * 10 + i + 1;
      end
      if ($countones(str) > 1) overlap++;
      if ((str != 5'd0) && (ir_in !== exp_ir)) ir_bad++;
      prev_str = str;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one transaction; on return the bench sits just after a negedge
  task automatic do_cmd(input logic [IRW-1:0] ir, input logic [SR-1:0] data,
                        input logic lb, input logic [SR-1:0] p, input int rdelay,
                        input bit hold_next);
    logic [SR-1:0] exp_rsp;
    bit skip;
    int exp_lat;
    int t0;
    int waited;
    int hold_bad;
    skip = 1'b0;
`ifdef DBG_HOST_IR_CACHE_EN
    skip = m_cache_vld && (ir == m_cache_ir);
`endif
    m_cache_vld = 1'b1;
    m_cache_ir  = ir;
    exp_rsp = lb ? data : p;
    exp_lat = LAT - (skip ? PER : 0);

    loop_mode = lb; pat = p; exp_data = data; exp_ir = ir;
    sdr_idx = 0; tdi_bad = 0; seq = 0; overlap = 0; ir_bad = 0; prev_str = '0;
    for (int i = 0; i < 5; i++) n_str[i] = 0;
    mon_en = 1'b1;

    waited = 0;
    while (!cmd_ready && waited < 200) begin @(negedge clk); waited++; end
    chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_data = data;
    @(posedge clk); #1;
    t0 = cyc;
    cmd_valid = 1'b0; cmd_ir = ~ir; cmd_data = ~data;
    chk("busy_after_accept", 64'(busy), 64'd1);

    waited = 0;
    while (!rsp_valid && waited < 2000) begin @(negedge clk); waited++; end
    chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    chk("latency", 64'(cyc - t0), 64'(exp_lat));
    chk("rsp_data", 64'(rsp_data), 64'(exp_rsp));

    hold_bad = 0;
    if (hold_next) cmd_valid = 1'b1;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || cmd_ready !== 1'b0 || busy !== 1'b1)
        hold_bad++;
    end
    chk("hold_stable", 64'(hold_bad), 64'd0);

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_dropped", 64'(rsp_valid), 64'd0);
    chk("idle_after_rsp", {62'd0, busy, cmd_ready}, 64'd1);
    mon_en = 1'b0;

    chk("n_uir", 64'(n_str[0]), skip ? 64'd0 : 64'(PER));
    chk("n_cdr", 64'(n_str[1]), 64'(PER));
    chk("n_sdr", 64'(n_str[2]), 64'(SR * PER));
    chk("n_udr", 64'(n_str[3]), 64'(PER));
    chk("n_rti", 64'(n_str[4]), 64'(PER));
    chk("strobe_overlap", 64'(overlap), 64'd0);
    chk("strobe_order", 64'(seq), skip ? 64'd2345 : 64'd12345);
    chk("ir_in_during", 64'(ir_bad), 64'd0);
    chk("sdr_periods", 64'(sdr_idx), 64'(SR));
    chk("tdi_bits", 64'(tdi_bad), 64'd0);
    chk("ir_in_hold", 64'(ir_in), 64'(ir));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int waited;
    logic [SR-1:0] d, p;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
    mon_en = 1'b0; loop_mode = 1'b1; pat = '0; exp_data = '0; exp_ir = '0;
    sdr_idx = 0; tdi_bad = 0; seq = 0; overlap = 0; ir_bad = 0; prev_str = '0;
    for (int i = 0; i < 5; i++) n_str[i] = 0;
    m_cache_vld = 1'b0; m_cache_ir = '0;

    // Reset state
    #1;
    chk("reset_outputs", 64'(outs_all), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("cmd_ready_at_release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    // Loopback, default latency, strobe sequence
    do_cmd(2'b01, 38'h2A_5A5A_A5A5, 1'b1, '0, 0, 1'b0);

    // Backpressure with a second command pending throughout
    do_cmd(2'b01, 38'h15_C3C3_3C3C, 1'b1, '0, 50, 1'b1);

    // Capture pattern: only the 5th sampled bit is 1
    do_cmd(2'b01, 38'h3F_FFFF_FFFF, 1'b0, 38'h10, 2, 1'b0);

    // Reset during shift
    loop_mode = 1'b1; exp_data = 38'h0A_BCDE_F012; exp_ir = 2'b11;
    sdr_idx = 0; mon_en = 1'b1;
    cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_data = 38'h0A_BCDE_F012;
    @(negedge clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (sdr_idx < 20 && waited < 1000) begin @(negedge clk); waited++; end
    chk("reached_bit20", 64'(sdr_idx), 64'd20);
    mon_en = 1'b0;
    reset = 1'b1;
    #1 chk("reset_mid_sdr", 64'(outs_all), 64'd0);
    m_cache_vld = 1'b0;
    waited = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsp_valid !== 1'b0) waited++; end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (rsp_valid !== 1'b0 || busy !== 1'b0) waited++; end
    chk("no_rsp_after_abort", 64'(waited), 64'd0);

    // IR sequence 10, 10, 11 (second skips UIR when the cache is built in)
    do_cmd(2'b10, 38'h01_2345_6789, 1'b1, '0, 1, 1'b0);
    do_cmd(2'b10, 38'h2F_EDCB_A987, 1'b1, '0, 0, 1'b0);
    do_cmd(2'b11, 38'h33_0F0F_F0F0, 1'b1, '0, 0, 1'b0);

    // Randomized commands
    for (int n = 0; n < 6; n++) begin
      d = SR'({$urandom(), $urandom()});
      p = SR'({$urandom(), $urandom()});
      do_cmd(IRW'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)), p,
             int'($urandom_range(0, 5)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
